// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state type, state
// encodings and a helper that sizes the bit counter.
package serial_adder_pkg;

    // FSM state, kept as plain vector constants for compatibility with
    // older tools that handle localparam encodings better than enums.
    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_ADD  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Bit counter width: enough to hold WIDTH-1, never narrower than 1 bit.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder; the only arithmetic element in the serial datapath.
module full_adder (
    input  logic a_in,
    input  logic b_in,
    input  logic c_in,
    output logic sum_out,
    output logic carry_out
);

    assign sum_out   = a_in ^ b_in ^ c_in;
    assign carry_out = (a_in & b_in) | (c_in & (a_in ^ b_in));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: captures two WIDTH-bit operands plus carry-in on start,
// adds one bit pair per cycle LSB first through a single full adder, and
// presents {carry_out, sum_out} with a one-cycle done pulse.
// Optional feature: define SERIAL_ADDER_OVF_EN to add ovf_out, the
// two's-complement signed overflow flag of the completed addition.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             busy,
    output logic             done
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf_out
`endif
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_carry;
    logic             last_bit;
    logic             finish;

    // One full adder serves every bit position in turn.
    full_adder u_fa (
        .a_in      (a_sh[0]),
        .b_in      (b_sh[0]),
        .c_in      (carry_q),
        .sum_out   (fa_sum),
        .carry_out (fa_carry)
    );

    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign finish   = (state == ST_ADD) && last_bit;
    assign busy     = (state == ST_ADD) || (state == ST_DONE);
    assign done     = (state == ST_DONE);

    // Result shift register next value: new sum bit enters at the MSB end.
    always_comb begin
        // NOTE: default assignment first so every path drives res_next and no latch is inferred.
        res_next            = res_sh >> 1;
        res_next[WIDTH-1]   = fa_sum;
    end

    // FSM and serial datapath; result outputs only update on the final bit.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the operand/result shift registers are reset too, so no X ever reaches the outputs.
        if (!rst_n) begin
            state     <= ST_IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            carry_q   <= 1'b0;
            cnt       <= '0;
            sum_out   <= '0;
            carry_out <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_sh    <= a_in;
                        b_sh    <= b_in;
                        carry_q <= c_in;
                        cnt     <= '0;
                        state   <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    carry_q <= fa_carry;
                    res_sh  <= res_next;
                    cnt     <= cnt + CW'(1);
                    if (last_bit) begin
                        sum_out   <= res_next;
                        carry_out <= fa_carry;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // Signed overflow: carry into the top bit differs from carry out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_out <= 1'b0;
        end else if (finish) begin
            ovf_out <= carry_q ^ fa_carry;
        end
    end
`else
    // Without the overflow option the finish strobe only feeds lint hygiene.
    logic unused_finish;
    assign unused_finish = finish;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH = 8, 1 and 16.
// Directed tables with hand-computed results, plus hand-written sequences
// for a start pulse during an operation and a reset mid-operation.
module tb_serial_adder;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        logic [31:0] s;
        logic        co;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        start_v [3];
    logic [31:0] a_v     [3];
    logic [31:0] b_v     [3];
    logic        c_v     [3];
    logic [31:0] sum_v   [3];
    logic        co_v    [3];
    logic        busy_v  [3];
    logic        done_v  [3];
    logic        ov_v    [3];
    int          widths  [3] = '{8, 1, 16};

    logic [7:0]  sum8;
    logic [0:0]  sum1;
    logic [15:0] sum16;
    logic        co8, co1, co16;
    logic        busy8, busy1, busy16;
    logic        done8, done1, done16;
    logic        ov8, ov1, ov16;

    int n_checks = 0;
    int n_errors = 0;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]),
        .a_in(a_v[0][7:0]), .b_in(b_v[0][7:0]), .c_in(c_v[0]),
        .sum_out(sum8), .carry_out(co8), .busy(busy8), .done(done8)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf_out(ov8)
`endif
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]),
        .a_in(a_v[1][0:0]), .b_in(b_v[1][0:0]), .c_in(c_v[1]),
        .sum_out(sum1), .carry_out(co1), .busy(busy1), .done(done1)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf_out(ov1)
`endif
    );

    serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]),
        .a_in(a_v[2][15:0]), .b_in(b_v[2][15:0]), .c_in(c_v[2]),
        .sum_out(sum16), .carry_out(co16), .busy(busy16), .done(done16)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf_out(ov16)
`endif
    );

`ifndef SERIAL_ADDER_OVF_EN
    assign ov8  = 1'b0;
    assign ov1  = 1'b0;
    assign ov16 = 1'b0;
`endif

    always_comb begin
        sum_v[0]  = 32'(sum8);
        sum_v[1]  = 32'(sum1);
        sum_v[2]  = 32'(sum16);
        co_v[0]   = co8;
        co_v[1]   = co1;
        co_v[2]   = co16;
        busy_v[0] = busy8;
        busy_v[1] = busy1;
        busy_v[2] = busy16;
        done_v[0] = done8;
        done_v[1] = done1;
        done_v[2] = done16;
        ov_v[0]   = ov8;
        ov_v[1]   = ov1;
        ov_v[2]   = ov16;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One complete addition on DUT k, entered and left on a falling edge.
    // glitch_at >= 0 pulses start with other operands that many cycles in.
    task automatic op(input int k, input logic [31:0] a, input logic [31:0] b, input logic c,
                      input logic [31:0] es, input logic eco, input int glitch_at, input string tag);
        logic [31:0] pre;
        logic        hold_bad;
        logic        eov;
        int          lat;
        int          w;
        w   = widths[k];
        eov = (a[w-1] == b[w-1]) && (es[w-1] != a[w-1]);
        pre = sum_v[k];
        a_v[k] = a;
        b_v[k] = b;
        c_v[k] = c;
        start_v[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[k] = 1'b0;
        a_v[k] = ~a;
        b_v[k] = $urandom;
        c_v[k] = ~c;
        lat = 0;
        hold_bad = 1'b0;
        while (!done_v[k] && lat < 80) begin
            if (sum_v[k] !== pre || busy_v[k] !== 1'b1) hold_bad = 1'b1;
            if (lat == glitch_at) begin
                start_v[k] = 1'b1;
                a_v[k] = 32'h5a5a_a5a5;
                b_v[k] = 32'h1234_0f0f;
                c_v[k] = 1'b1;
            end else begin
                start_v[k] = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start_v[k] = 1'b0;
        // done is high in the cycle following edge N+WIDTH.
        check($sformatf("%s.latency", tag), lat, w);
        check($sformatf("%s.hold", tag), 32'(hold_bad), 0);
        check($sformatf("%s.sum", tag), sum_v[k], es);
        check($sformatf("%s.carry", tag), 32'(co_v[k]), 32'(eco));
        check($sformatf("%s.busy_at_done", tag), 32'(busy_v[k]), 1);
`ifdef SERIAL_ADDER_OVF_EN
        check($sformatf("%s.ovf", tag), 32'(ov_v[k]), 32'(eov));
`endif
        @(negedge clk);
        check($sformatf("%s.done_pulse", tag), 32'(done_v[k]), 0);
        check($sformatf("%s.idle_busy", tag), 32'(busy_v[k]), 0);
    endtask

    initial begin
        vec_t        v8 [8];
        vec_t        v1 [8];
        logic [16:0] ref16;
        logic [31:0] ra, rb;
        logic        rc;
        logic        done_seen;

        v8[0] = '{32'd3,   32'd5,   1'b0, 32'd8,   1'b0};
        v8[1] = '{32'd255, 32'd0,   1'b1, 32'd0,   1'b1};
        v8[2] = '{32'd127, 32'd1,   1'b0, 32'd128, 1'b0};
        v8[3] = '{32'd255, 32'd255, 1'b1, 32'd255, 1'b1};
        v8[4] = '{32'd0,   32'd0,   1'b0, 32'd0,   1'b0};
        v8[5] = '{32'd170, 32'd85,  1'b0, 32'd255, 1'b0};
        v8[6] = '{32'd128, 32'd128, 1'b0, 32'd0,   1'b1};
        v8[7] = '{32'd200, 32'd100, 1'b1, 32'd45,  1'b1};

        v1[0] = '{32'd0, 32'd0, 1'b0, 32'd0, 1'b0};
        v1[1] = '{32'd0, 32'd0, 1'b1, 32'd1, 1'b0};
        v1[2] = '{32'd0, 32'd1, 1'b0, 32'd1, 1'b0};
        v1[3] = '{32'd0, 32'd1, 1'b1, 32'd0, 1'b1};
        v1[4] = '{32'd1, 32'd0, 1'b0, 32'd1, 1'b0};
        v1[5] = '{32'd1, 32'd0, 1'b1, 32'd0, 1'b1};
        v1[6] = '{32'd1, 32'd1, 1'b0, 32'd0, 1'b1};
        v1[7] = '{32'd1, 32'd1, 1'b1, 32'd1, 1'b1};

        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start_v[k] = 1'b0;
            a_v[k] = '0;
            b_v[k] = '0;
            c_v[k] = 1'b0;
        end

        // Reset state of all three instances.
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst%0d.sum", k),   sum_v[k], 0);
            check($sformatf("rst%0d.carry", k), 32'(co_v[k]), 0);
            check($sformatf("rst%0d.busy", k),  32'(busy_v[k]), 0);
            check($sformatf("rst%0d.done", k),  32'(done_v[k]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // WIDTH=8 directed table; the first start lands on the first edge out of reset.
        for (int i = 0; i < 8; i++)
            op(0, v8[i].a, v8[i].b, v8[i].c, v8[i].s, v8[i].co, -1, $sformatf("w8[%0d]", i));

        // Start pulsed 3 cycles into an operation must be ignored.
        op(0, 32'd10, 32'd20, 1'b0, 32'd30, 1'b0, 3, "w8_glitch");

        // Reset 4 cycles into an operation.
        start_v[0] = 1'b1;
        a_v[0] = 32'd100;
        b_v[0] = 32'd50;
        c_v[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst.sum",   sum_v[0], 0);
        check("midrst.carry", 32'(co_v[0]), 0);
        check("midrst.busy",  32'(busy_v[0]), 0);
        check("midrst.done",  32'(done_v[0]), 0);
        done_seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done_v[0]) done_seen = 1'b1;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done_v[0]) done_seen = 1'b1;
        end
        check("midrst.no_done", 32'(done_seen), 0);
        op(0, 32'd100, 32'd50, 1'b0, 32'd150, 1'b0, -1, "w8_after_rst");

        // WIDTH=1 full-adder truth table.
        for (int i = 0; i < 8; i++)
            op(1, v1[i].a, v1[i].b, v1[i].c, v1[i].s, v1[i].co, -1, $sformatf("w1[%0d]", i));

        // WIDTH=16 back-to-back random operations against a + b + c.
        for (int i = 0; i < 1000; i++) begin
            ra = 32'($urandom_range(0, 65535));
            rb = 32'($urandom_range(0, 65535));
            rc = 1'($urandom_range(0, 1));
            ref16 = 17'(ra) + 17'(rb) + 17'(rc);
            op(2, ra, rb, rc, 32'(ref16[15:0]), ref16[16], -1, $sformatf("w16[%0d]", i));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 1 to 32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a new addition; sampled only in IDLE.
REQ-005 a_in  input  WIDTH  operand A, captured on accepted start.
REQ-006 b_in  input  WIDTH  operand B, captured on accepted start.
REQ-007 c_in  input  1  carry-in, captured on accepted start.
REQ-008 sum_out  output  WIDTH  result sum, valid from done and held until next accepted start.
REQ-009 carry_out  output  1  final carry out of bit WIDTH-1, same validity as sum_out.
REQ-010 busy  output  1  high in ADD and DONE states.
REQ-011 done  output  1  single-cycle pulse marking result valid.

Function
REQ-012 FSM states: IDLE, ADD, DONE; encoding is free.
REQ-013 IDLE: start=1 captures a_in, b_in, c_in into shift registers, clears bit counter to 0, goes to ADD; start=0 stays IDLE.
REQ-014 ADD: each cycle adds one bit pair, LSB first, with running carry; shifts sum bit into result register MSB end; increments counter.
REQ-015 ADD to DONE after exactly WIDTH ADD cycles, i.e. when counter = WIDTH-1.
REQ-016 DONE: done=1 for exactly one cycle, sum_out/carry_out final; unconditional transition to IDLE.
REQ-017 Latency: start sampled at edge N gives done=1 in cycle after edge N+WIDTH; next start accepted at edge N+WIDTH+2 at the earliest.
REQ-018 start while busy is ignored; captured operands are not disturbed.
REQ-019 Input changes on a_in/b_in/c_in after capture have no effect on the running operation.
REQ-020 Arithmetic: {carry_out, sum_out} = a_in + b_in + c_in, modulo 2^(WIDTH+1); no saturation.
REQ-021 sum_out and carry_out are registered and do not change during ADD until the operation completes; partial results are not observable.
REQ-022 WIDTH=1: one ADD cycle, behaviour identical to a single full adder registered.

Reset
REQ-023 rst_n low forces IDLE, sum_out=0, carry_out=0, busy=0, done=0, counter=0, running carry=0, immediately and asynchronously.
REQ-024 Reset mid-operation abandons the addition; no done pulse is produced for it.
REQ-025 Reset deassertion is synchronous to clk externally; first start is accepted on the first edge with rst_n high.

Configuration
REQ-026 Macro SERIAL_ADDER_OVF_EN, when defined, adds output ovf_out (1 bit) = carry into bit WIDTH-1 XOR carry_out, i.e. two's-complement signed overflow, with the same validity and reset (0) as carry_out.
REQ-027 Without SERIAL_ADDER_OVF_EN, no ovf_out port and no associated logic exist; all other behaviour is unchanged.

Structure
REQ-028 Shared package serial_adder_pkg holds the FSM state typedef and state encoding constants; WIDTH stays a module parameter.
REQ-029 The per-bit add is one instance of sub-module full_adder (ports a_in, b_in, c_in, sum_out, carry_out); the datapath contains no other adder.

Verification
REQ-030 WIDTH=8: a_in=3, b_in=5, c_in=0, start -> done 9 cycles after start edge, sum_out=8, carry_out=0.
REQ-031 WIDTH=8: a_in=255, b_in=0, c_in=1 -> sum_out=0, carry_out=1; with OVF_EN, a_in=127, b_in=1, c_in=0 -> sum_out=128, ovf_out=1.
REQ-032 start pulsed again 3 cycles into the operation with different operands -> ignored; first result delivered unchanged, one done pulse only.
REQ-033 rst_n low 4 cycles into the operation -> outputs 0 immediately, no done; a new start after reset gives a correct result.
REQ-034 WIDTH=1: all 8 combinations of {a,b,c} -> sum/carry match the full-adder truth table, done 2 cycles after each start.
REQ-035 WIDTH=16: 1000 random back-to-back operations checked against a + b + c_in reference model.
